m_dm_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: CPU M stage (port C) and bridge/external master (port E).

---
 rtl/m_dm_arbiter_if.sv | 18 +
 rtl/m_dm_arbiter.sv | 88 ++++++++
 tb/tb_m_dm_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/m_dm_arbiter_if.sv
// Requester-side access port for the data-memory arbiter: request fields in, grant and read return out.
interface m_dm_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [BW-1:0] byteen;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, byteen, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, byteen, output gnt, rvalid, rdata);
endinterface

// File: rtl/m_dm_arbiter.sv
// Single-port data-memory arbiter between CPU (c) and external master (e).
// C wins conflicts until E has lost MAX_WAIT times; reads return one cycle later to their issuer.
module m_dm_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  m_dm_arbiter_if.slave        c,
  m_dm_arbiter_if.slave        e,
  output logic                 dm_en,
  output logic [3:0]           dm_byteen,
  output logic [31:0]          dm_addr,
  output logic [31:0]          dm_wdata,
  input  logic [31:0]          dm_rdata
);
  localparam int unsigned CW = 4;
  localparam logic [CW:0] MAX_W = 5'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;
  logic [CW:0]   wait_diff;
  logic          e_forced;
  logic          rd_pend;
  logic          rd_owner;
  logic          c_gnt;
  logic          e_gnt;
  logic          gnt_we;

  // Sign bit of the widened difference tells whether E has aged enough to win.
  assign wait_diff = {1'b0, wait_cnt} - MAX_W;
  assign e_forced  = ~wait_diff[CW];

  always_comb begin
    c_gnt = 1'b0;
    e_gnt = 1'b0;
    if (!reset) begin
      if (c.req && e.req) begin
        if (e_forced) e_gnt = 1'b1;
        else          c_gnt = 1'b1;
      end else begin
        c_gnt = c.req;
        e_gnt = e.req;
      end
    end
  end

  assign c.gnt = c_gnt;
  assign e.gnt = e_gnt;

  always_comb begin
    dm_en     = 1'b0;
    dm_byteen = '0;
    dm_addr   = '0;
    dm_wdata  = '0;
    gnt_we    = 1'b0;
    if (c_gnt) begin
      dm_en     = 1'b1;
      gnt_we    = c.we;
      dm_addr   = {c.addr[31:2], 2'b00};
      dm_wdata  = c.wdata;
      dm_byteen = c.we ? c.byteen : 4'b0000;
    end else if (e_gnt) begin
      dm_en     = 1'b1;
      gnt_we    = e.we;
      dm_addr   = {e.addr[31:2], 2'b00};
      dm_wdata  = e.wdata;
      dm_byteen = e.we ? e.byteen : 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      if (e_gnt || !e.req)  wait_cnt <= '0;
      else if (!e_forced)   wait_cnt <= wait_cnt + 4'd1;
      rd_pend <= dm_en && !gnt_we;
      if (dm_en && !gnt_we) rd_owner <= e_gnt;
    end
  end

  // A return still in flight when reset hits is dropped, not delivered.
  assign c.rvalid = rd_pend && !rd_owner && !reset;
  assign e.rvalid = rd_pend &&  rd_owner && !reset;
  assign c.rdata  = c.rvalid ? dm_rdata : 32'h0;
  assign e.rdata  = e.rvalid ? dm_rdata : 32'h0;
endmodule

// File: tb/tb_m_dm_arbiter.sv
// Scoreboard bench for m_dm_arbiter: per-cycle grant/DM-drive checks and queued read-return checks.
module tb_m_dm_arbiter;
  logic        clk;
  logic        reset;
  logic [31:0] dm_rdata;
  logic        dm_en0, dm_en1;
  logic [3:0]  dm_byteen0, dm_byteen1;
  logic [31:0] dm_addr0, dm_addr1, dm_wdata0, dm_wdata1;

  m_dm_arbiter_if c0 ();
  m_dm_arbiter_if e0 ();
  m_dm_arbiter_if c1 ();
  m_dm_arbiter_if e1 ();

  m_dm_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .c(c0), .e(e0),
    .dm_en(dm_en0), .dm_byteen(dm_byteen0), .dm_addr(dm_addr0),
    .dm_wdata(dm_wdata0), .dm_rdata(dm_rdata)
  );

  m_dm_arbiter #(.MAX_WAIT(0)) dut_w0 (
    .clk(clk), .reset(reset), .c(c1), .e(e1),
    .dm_en(dm_en1), .dm_byteen(dm_byteen1), .dm_addr(dm_addr1),
    .dm_wdata(dm_wdata1), .dm_rdata(dm_rdata)
  );

  typedef struct {
    bit          cv;
    bit          ev;
    logic [31:0] d;
  } ret_t;

  ret_t        ret_q[$];
  int          n_checks;
  int          n_fail;
  logic [31:0] fixed_rd;
  bit          fixed_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_c(input bit req, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    c0.req = req; c0.we = we; c0.addr = a; c0.wdata = wd; c0.byteen = be;
  endtask

  task automatic set_e(input bit req, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    e0.req = req; e0.we = we; e0.addr = a; e0.wdata = wd; e0.byteen = be;
  endtask

  // One clock: check this cycle's outputs at negedge, queue the return it should cause.
  task automatic step(input bit xc, input bit xe, input bit xc1, input bit xe1);
    ret_t        r;
    ret_t        nr;
    logic [31:0] ea, ew, nxt;
    logic [3:0]  eb;
    bit          rd;
    @(negedge clk);
    check("c_gnt", c0.gnt, xc);
    check("e_gnt", e0.gnt, xe);
    ea = 32'h0; ew = 32'h0; eb = 4'h0; rd = 1'b0;
    if (xc) begin
      ea = {c0.addr[31:2], 2'b00}; ew = c0.wdata; eb = c0.we ? c0.byteen : 4'h0; rd = !c0.we;
    end else if (xe) begin
      ea = {e0.addr[31:2], 2'b00}; ew = e0.wdata; eb = e0.we ? e0.byteen : 4'h0; rd = !e0.we;
    end
    check("dm_en", dm_en0, xc | xe);
    check("dm_addr", dm_addr0, ea);
    check("dm_wdata", dm_wdata0, ew);
    check("dm_byteen", dm_byteen0, eb);
    r = ret_q.pop_front();
    if (reset) begin
      r.cv = 1'b0; r.ev = 1'b0;
    end
    check("c_rvalid", c0.rvalid, r.cv);
    check("c_rdata", c0.rdata, r.cv ? r.d : 32'h0);
    check("e_rvalid", e0.rvalid, r.ev);
    check("e_rdata", e0.rdata, r.ev ? r.d : 32'h0);
    check("w0_c_gnt", c1.gnt, xc1);
    check("w0_e_gnt", e1.gnt, xe1);
    nxt = fixed_en ? fixed_rd : $urandom;
    fixed_en = 1'b0;
    nr.cv = !reset && xc && rd;
    nr.ev = !reset && xe && rd;
    nr.d  = nxt;
    ret_q.push_back(nr);
    @(posedge clk);
    #1;
    dm_rdata = nxt;
  endtask

  initial begin
    ret_t z;
    n_checks = 0;
    n_fail   = 0;
    fixed_en = 1'b0;
    fixed_rd = 32'h0;
    reset    = 1'b1;
    dm_rdata = 32'h0;
    set_c(0, 0, 0, 0, 0);
    set_e(0, 0, 0, 0, 0);
    c1.req = 0; c1.we = 1; c1.addr = 32'h100; c1.wdata = 32'h1; c1.byteen = 4'hf;
    e1.req = 0; e1.we = 1; e1.addr = 32'h200; e1.wdata = 32'h2; e1.byteen = 4'hf;
    z.cv = 1'b0; z.ev = 1'b0; z.d = 32'h0;
    ret_q.push_back(z);

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    reset = 1'b0;
    step(0, 0, 0, 0);

    // C read alone with fixed return data
    set_c(1, 0, 32'h0000_1006, 32'h0, 4'hf);
    fixed_rd = 32'hA5A5_0001; fixed_en = 1'b1;
    step(1, 0, 0, 0);
    set_c(0, 0, 0, 0, 0);
    step(0, 0, 0, 0);

    // E single-lane write, then a no-op write from C
    set_e(1, 1, 32'h0000_2002, 32'h00CC_0000, 4'b0100);
    step(0, 1, 0, 0);
    set_e(0, 0, 0, 0, 0);
    set_c(1, 1, 32'h0000_0023, 32'h1234_5678, 4'b0000);
    step(1, 0, 0, 0);
    set_c(0, 0, 0, 0, 0);
    step(0, 0, 0, 0);

    // C read then E read on consecutive cycles
    set_c(1, 0, 32'h0000_0040, 32'h0, 4'hf);
    step(1, 0, 0, 0);
    set_c(0, 0, 0, 0, 0);
    set_e(1, 0, 32'h0000_0081, 32'h0, 4'hf);
    step(0, 1, 0, 0);
    set_e(0, 0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Sustained conflict: 4 C wins, one forced E win, 4 more C wins
    set_e(1, 0, 32'h0000_3000, 32'h0, 4'hf);
    for (int i = 0; i < 4; i++) begin
      set_c(1, 0, 32'h0000_4000 + 32'(i * 4), 32'h0, 4'hf);
      step(1, 0, 0, 0);
    end
    set_c(1, 1, 32'h0000_5000, 32'hDEAD_BEEF, 4'b0011);
    step(0, 1, 0, 0);
    set_e(1, 0, 32'h0000_3004, 32'h0, 4'hf);
    for (int i = 0; i < 4; i++) begin
      set_c(1, i[0], 32'h0000_6000 + 32'(i * 4), 32'h0F0F_0000 + 32'(i), 4'b1001);
      step(1, 0, 0, 0);
    end
    step(0, 1, 0, 0);
    set_c(0, 0, 0, 0, 0);
    set_e(0, 0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Reset during an in-flight C read; aging must restart from zero
    set_c(1, 0, 32'h0000_7000, 32'h0, 4'hf);
    set_e(1, 0, 32'h0000_7100, 32'h0, 4'hf);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    set_e(0, 0, 0, 0, 0);
    step(1, 0, 0, 0);
    set_c(0, 0, 0, 0, 0);
    reset = 1'b1;
    step(0, 0, 0, 0);
    reset = 1'b0;
    step(0, 0, 0, 0);
    set_c(1, 0, 32'h0000_7200, 32'h0, 4'hf);
    set_e(1, 0, 32'h0000_7300, 32'h0, 4'hf);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    set_c(0, 0, 0, 0, 0);
    set_e(0, 0, 0, 0, 0);
    step(0, 0, 0, 0);

    // MAX_WAIT=0 instance: E wins every conflict
    c1.req = 1; e1.req = 1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    e1.req = 0;
    step(0, 0, 1, 0);
    c1.req = 0; e1.req = 1;
    step(0, 0, 0, 1);
    c1.req = 1;
    step(0, 0, 0, 1);
    c1.req = 0; e1.req = 0;
    step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
